// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding, status-bit positions and FIFO depth for uart_tx_port.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam logic [2:0] FIFO_DEPTH = 3'd4;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: 4-entry byte FIFO; a push into a full FIFO is taken only when a pop happens alongside it.
module byte_fifo
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [2:0] count,
    output logic       full,
    output logic       empty
);
    logic [7:0] mem_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;
    logic       do_push, do_pop;

    assign empty   = cnt_q == 3'd0;
    assign full    = cnt_q == FIFO_DEPTH;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 2'd1;
            if (do_pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + {2'b0, do_push} - {2'b0, do_pop};
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: port-mapped UART transmitter (data + status registers, 4-byte FIFO, 8N1 framing).
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP (11-bit frame).
module uart_tx_port
    import uart_pkg::*;
#(
    parameter logic [7:0] ADDR_DATA    = 8'h04,
    parameter logic [7:0] ADDR_STAT    = 8'h05,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic [7:0] value_in,
    input  logic       wen,
    input  logic       ren,
    output logic [7:0] value_out,
    output logic       tx,
    output logic       busy
);
    localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     state_q;
    logic [7:0] baud_q, data_q, vout_q, vout_d, status, dout;
    logic [2:0] bit_q, count;
    logic       tx_q, wen_q, ren_q, ovf_q, ovf_d;
    logic       push, pop, full, empty, rd_edge, rd_stat, tc;

    assign push      = wen && !wen_q && address == ADDR_DATA;
    assign rd_edge   = ren && !ren_q;
    assign rd_stat   = rd_edge && address == ADDR_STAT;
    assign pop       = state_q == S_IDLE && !empty;
    assign tc        = baud_q == BAUD_MAX;
    assign tx        = tx_q;
    assign busy      = state_q != S_IDLE || !empty;
    assign value_out = vout_q;

    byte_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (value_in),
        .dout  (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Overflow: a dropped push sets it, a status read clears it, set wins.
    always_comb begin
        status                  = '0;
        status[ST_FULL]         = full;
        status[ST_EMPTY]        = empty;
        status[ST_BUSY]         = state_q != S_IDLE;
        status[ST_OVF]          = ovf_q;
        status[ST_CNT_LSB +: 3] = count;
        vout_d = rd_edge ? (rd_stat ? status : 8'h00) : vout_q;
        ovf_d  = (push && full && !pop) || (ovf_q && !rd_stat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q  <= 1'b0;
            ren_q  <= 1'b0;
            ovf_q  <= 1'b0;
            vout_q <= '0;
        end else begin
            wen_q  <= wen;
            ren_q  <= ren;
            ovf_q  <= ovf_d;
            vout_q <= vout_d;
        end
    end

    // tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            baud_q <= (state_q == S_IDLE || tc) ? '0 : baud_q + 8'd1;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        data_q  <= dout;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (tc) begin
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    tx_q <= data_q[bit_q];
                    if (tc) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= S_AFTER_DATA;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx_q <= ^data_q;
                    if (tc) state_q <= S_STOP;
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (tc) state_q <= S_IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed and randomized checks of uart_tx_port against a frame/status model.
// Build with UART_TX_PARITY_EN defined to exercise the 11-bit parity frame.
module tb_uart_tx_port;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0, rst = 1'b1, wen = 1'b0, ren = 1'b0, tx, busy;
    logic [7:0] address = 8'h00, value_in = 8'h00, value_out;
    int         total = 0, bad = 0;

    uart_tx_port #(.ADDR_DATA(8'h04), .ADDR_STAT(8'h05), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .value_in  (value_in),
        .wen       (wen),
        .ren       (ren),
        .value_out (value_out),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status byte as seen by software: queued bytes, frame in progress, sticky overflow.
    function automatic logic [7:0] stat(input int queued, input bit active, input bit ovf);
        return {1'b0, 3'(queued), ovf, active, queued == 0, queued == 4};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        value_in = d;
        wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        @(negedge clk);
        address = a;
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        v = value_out;
    endtask

    // Expected line: start 0, data LSB first, optional even parity, stop 1; each CPB cycles.
    task automatic frame(input string tag, input logic [7:0] b, input bit chained, output int waited);
        logic [10:0] bits;
        bit          ok;
        bits = {2'b11, b, 1'b0};
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        waited = 0;
        if (chained) begin
            @(negedge clk);
            chk({tag, " gap"}, 32'(tx), 1);
            @(negedge clk);
        end else begin
            @(negedge clk);
            while (tx !== 1'b0 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
        end
        for (int k = 0; k < NB; k++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (tx !== bits[k]) ok = 1'b0;
            end
            chk($sformatf("%s bit%0d", tag, k), 32'(ok), 1);
        end
    endtask

    task automatic quiet(input string tag);
        bit ok;
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk(tag, 32'(ok), 1);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] bytes[$];
        int         w, n;
        repeat (3) @(negedge clk);
        chk("rst tx", 32'(tx), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst value_out", 32'(value_out), 0);
        rst = 1'b0;
        rd(8'h05, v);
        chk("stat after rst", 32'(v), 32'(stat(0, 0, 0)));
        repeat (3) @(negedge clk);
        chk("value_out hold", 32'(value_out), 32'h02);
        rd(8'h10, v);
        chk("other addr read", 32'(v), 0);

        wr(8'h04, 8'hA5);
        chk("busy after write", 32'(busy), 1);
        frame("a5", 8'hA5, 1'b0, w);
        chk("a5 start latency", 32'(w), 1);
        @(negedge clk);
        chk("a5 idle tx", 32'(tx), 1);
        chk("a5 busy low", 32'(busy), 0);

        fork
            begin
                wr(8'h04, 8'h11);
                @(negedge clk);
                address = 8'h04;
                value_in = 8'h22;
                wen = 1'b1;
                repeat (3) @(negedge clk);
                wen = 1'b0;
                rd(8'h05, v);
                chk("held wen stat", 32'(v), 32'(stat(1, 1, 0)));
            end
            begin
                frame("h11", 8'h11, 1'b0, w);
                frame("h22", 8'h22, 1'b1, w);
            end
        join
        quiet("held wen single push");

        fork
            begin
                for (int i = 1; i <= 6; i++) wr(8'h04, 8'(i));
                rd(8'h05, v);
                chk("ovf stat", 32'(v), 32'(stat(4, 1, 1)));
                rd(8'h05, v);
                chk("ovf cleared", 32'(v), 32'(stat(4, 1, 0)));
            end
            begin
                frame("b1", 8'h01, 1'b0, w);
                for (int j = 2; j <= 5; j++) frame($sformatf("b%0d", j), 8'(j), 1'b1, w);
            end
        join
        quiet("h06 dropped");
        rd(8'h05, v);
        chk("stat idle", 32'(v), 32'(stat(0, 0, 0)));

        repeat (3) begin
            n = $urandom_range(1, 5);
            bytes.delete();
            for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
            fork
                begin
                    foreach (bytes[i]) wr(8'h04, bytes[i]);
                    rd(8'h05, v);
                    chk("rand stat", 32'(v), 32'(stat(n - 1, 1, 0)));
                end
                begin
                    foreach (bytes[i]) frame($sformatf("rand%0h", bytes[i]), bytes[i], i != 0, w);
                end
            join
            quiet("rand quiet");
        end

        fork
            begin
                wr(8'h04, 8'hFF);
                wr(8'h04, 8'h3C);
                wr(8'h04, 8'h5A);
            end
            begin
                w = 0;
                @(negedge clk);
                while (tx !== 1'b0 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                repeat (3 * CPB) @(negedge clk);
            end
        join
        chk("ff in flight", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid rst tx", 32'(tx), 1);
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst value_out", 32'(value_out), 0);
        @(negedge clk);
        rst = 1'b0;
        rd(8'h05, v);
        chk("stat after mid rst", 32'(v), 32'(stat(0, 0, 0)));
        quiet("no frame after rst");

`ifdef UART_TX_PARITY_EN
        wr(8'h04, 8'h07);
        frame("p07", 8'h07, 1'b0, w);
        wr(8'h04, 8'h03);
        frame("p03", 8'h03, 1'b0, w);
        quiet("parity quiet");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
